// File: rtl/buffer_pkg.sv
// Shared widths, element type and FSM state encodings for the buffer read controller.
package buffer_pkg;

  // Read pointer width for a power-of-two buffer depth (at least one bit).
  function automatic int unsigned addr_w(input int unsigned size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  // Occupancy width: must represent 0..size inclusive.
  function automatic int unsigned cnt_w(input int unsigned size);
    return $clog2(size) + 1;
  endfunction

  localparam int unsigned ELEM_W = 8;
  typedef logic [ELEM_W-1:0] elem_t;

  // Window FSM: EMPTY has no pending window, HOLD presents one to the consumer.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

endpackage

// File: rtl/occupancy_counter.sv
// Buffer occupancy: adds WRITE_SIZE per accepted push, removes STRIDE per window load.
module occupancy_counter
  import buffer_pkg::*;
#(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned WRITE_SIZE = 2,
  parameter int unsigned STRIDE     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_push,
  input  logic                     retire,
  output logic [cnt_w(SIZE)-1:0]   count,
  output logic                     space_ok,
  output logic                     push_acc
);

  localparam int unsigned CNT_W = cnt_w(SIZE);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Free-space test and push acceptance, decoded from the registered count.
  always_comb begin
    space_ok = (count_q <= CNT_W'(SIZE - WRITE_SIZE));
    push_acc = wr_push & space_ok;
  end

  // Push and retire both apply in one cycle; flush wins over both.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = CNT_W'(0);
    end else begin
      count_d = count_q
              + (push_acc ? CNT_W'(WRITE_SIZE) : CNT_W'(0))
              - (retire   ? CNT_W'(STRIDE)     : CNT_W'(0));
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= CNT_W'(0);
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/buffer_read_ctrl.sv
// Sliding-window read controller over a circular buffer.
// Optional feature macro: BUFFER_READ_CTRL_OVF_EN adds a sticky overflow flag (ovf).
module buffer_read_ctrl
  import buffer_pkg::*;
#(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned WRITE_SIZE = 2,
  parameter int unsigned READ_SIZE  = 2,
  parameter int unsigned STRIDE     = 1,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wr_push,
  input  logic                                  flush,
  input  logic [0:READ_SIZE-1][DATA_WIDTH-1:0]  buf_data,
  output logic [addr_w(SIZE)-1:0]               read_addr,
  output logic [0:READ_SIZE-1][DATA_WIDTH-1:0]  win_data,
  output logic                                  win_valid,
  input  logic                                  win_ready,
  output logic                                  space_ok,
  output logic [cnt_w(SIZE)-1:0]                count
`ifdef BUFFER_READ_CTRL_OVF_EN
  ,
  output logic                                  ovf
`endif
);

  localparam int unsigned ADDR_W = addr_w(SIZE);
  localparam int unsigned CNT_W  = cnt_w(SIZE);

  logic [0:0]                             state_q;
  logic [0:0]                             state_d;
  logic [ADDR_W-1:0]                      read_addr_q;
  logic [ADDR_W-1:0]                      read_addr_d;
  logic [0:READ_SIZE-1][DATA_WIDTH-1:0]   win_data_q;
  logic [0:READ_SIZE-1][DATA_WIDTH-1:0]   win_data_d;
  logic                                   load_c;
  logic                                   push_acc_c;

  occupancy_counter #(
    .SIZE       (SIZE),
    .WRITE_SIZE (WRITE_SIZE),
    .STRIDE     (STRIDE)
  ) u_occupancy (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_push  (wr_push),
    .retire   (load_c),
    .count    (count),
    .space_ok (space_ok),
    .push_acc (push_acc_c)
  );

  // A new window loads when the slot is free (or being freed) and enough elements are present.
  always_comb begin
    load_c = ((state_q == ST_EMPTY) || win_ready)
           && (count >= CNT_W'(READ_SIZE))
           && !flush;
  end

  // Window FSM next state, pointer advance and window capture.
  always_comb begin
    state_d     = state_q;
    read_addr_d = read_addr_q;
    win_data_d  = win_data_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      read_addr_d = ADDR_W'(0);
      win_data_d  = '0;
    end else if (load_c) begin
      state_d     = ST_HOLD;
      read_addr_d = read_addr_q + ADDR_W'(STRIDE);
      win_data_d  = buf_data;
    end else if ((state_q == ST_HOLD) && win_ready) begin
      state_d     = ST_EMPTY;
    end
  end

  // Window state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      read_addr_q <= ADDR_W'(0);
      win_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      read_addr_q <= read_addr_d;
      win_data_q  <= win_data_d;
    end
  end

  assign read_addr = read_addr_q;
  assign win_data  = win_data_q;
  assign win_valid = (state_q == ST_HOLD);

`ifdef BUFFER_READ_CTRL_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // Sticky overflow: set by a push into a full buffer, cleared only by flush or reset.
  always_comb begin
    ovf_d = ovf_q;
    if (flush) begin
      ovf_d = 1'b0;
    end else if (wr_push && !space_ok) begin
      ovf_d = 1'b1;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
